// File: rtl/key_round_sequencer.sv
// AES-128 key-expansion sequencer: streams round keys 0..NUM_ROUNDS, using an external g_function per round.
// Optional KEY_SCHED_STORE_EN adds a readable round-key register file (rd_idx_i/rd_data_o).
module key_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned G_TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic [127:0] key_in_i,
  output logic         busy_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_data_o,
  output logic [3:0]   rk_idx_o,
  output logic         done_o,
  output logic         error_o,
  output logic         g_enable_o,
  output logic [31:0]  g_word_o,
  output logic [3:0]   g_round_o,
  input  logic [31:0]  g_result_i,
  input  logic         g_done_i,
  input  logic         g_state_err_i
`ifdef KEY_SCHED_STORE_EN
  ,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_data_o
`endif
);

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned TMO_W  = 8;
  localparam logic [IDX_W-1:0] LAST_RND  = IDX_W'(NUM_ROUNDS);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(G_TIMEOUT);

  typedef enum logic [2:0] {IDLE, EMIT, G_REQ, G_REL, XOR, FIN, ERR} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    round_cnt_q, round_cnt_d;
  logic [KEY_W-1:0]    rk_data_q, rk_data_d;
  logic [IDX_W-1:0]    rk_idx_q, rk_idx_d;
  logic                rk_valid_q, rk_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                g_enable_q, g_enable_d;
  logic [WORD_W-1:0]   g_word_q, g_word_d;
  logic [IDX_W-1:0]    g_round_q, g_round_d;
  logic [WORD_W-1:0]   t_q, t_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [WORD_W-1:0]   n0, n1, n2, n3;

  // Next round key: bitwise XOR chain of the g result through w0..w3
  always_comb begin
    n0 = rk_data_q[127:96] ^ t_q;
    n1 = n0 ^ rk_data_q[95:64];
    n2 = n1 ^ rk_data_q[63:32];
    n3 = n2 ^ rk_data_q[31:0];
  end

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    rk_data_d   = rk_data_q;
    rk_idx_d    = rk_idx_q;
    rk_valid_d  = rk_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    g_enable_d  = g_enable_q;
    g_word_d    = g_word_q;
    g_round_d   = g_round_q;
    t_d         = t_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rk_data_d   = key_in_i;
          round_cnt_d = '0;
          rk_idx_d    = '0;
          rk_valid_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (rk_valid_q && rk_ready_i) begin
          rk_valid_d = 1'b0;
          if (round_cnt_q == LAST_RND) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            round_cnt_d = round_cnt_q + IDX_W'(1);
            g_enable_d  = 1'b1;
            g_word_d    = rk_data_q[31:0];
            g_round_d   = round_cnt_q;
            tmo_d       = '0;
            state_d     = G_REQ;
          end
        end
      end
      G_REQ: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (g_done_i) begin
          t_d        = g_result_i;
          g_enable_d = 1'b0;
          state_d    = G_REL;
        end else if (tmo_d == TMO_LIMIT) begin
          error_d    = 1'b1;
          g_enable_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = ERR;
        end
      end
      G_REL: begin
        // Wait for g_function to drop done so the next request cannot see a stale completion
        if (!g_done_i) begin
          state_d = XOR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_LIMIT) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ERR;
          end
        end
      end
      XOR: begin
        rk_data_d  = {n0, n1, n2, n3};
        rk_idx_d   = round_cnt_q;
        rk_valid_d = 1'b1;
        state_d    = EMIT;
      end
      FIN: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = ERR;
      end
    endcase

    // g_function fault aborts any active expansion
    if (g_state_err_i && (state_q != IDLE)) begin
      error_d    = 1'b1;
      g_enable_d = 1'b0;
      busy_d     = 1'b0;
      rk_valid_d = 1'b0;
      done_d     = 1'b0;
      state_d    = ERR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      round_cnt_q <= '0;
      rk_data_q   <= '0;
      rk_idx_q    <= '0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      g_enable_q  <= 1'b0;
      g_word_q    <= '0;
      g_round_q   <= '0;
      t_q         <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      rk_data_q   <= rk_data_d;
      rk_idx_q    <= rk_idx_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      g_enable_q  <= g_enable_d;
      g_word_q    <= g_word_d;
      g_round_q   <= g_round_d;
      t_q         <= t_d;
      tmo_q       <= tmo_d;
    end
  end

  assign busy_o     = busy_q;
  assign rk_valid_o = rk_valid_q;
  assign rk_data_o  = rk_data_q;
  assign rk_idx_o   = rk_idx_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign g_enable_o = g_enable_q;
  assign g_word_o   = g_word_q;
  assign g_round_o  = g_round_q;

`ifdef KEY_SCHED_STORE_EN
  logic [KEY_W-1:0] regfile_q [NUM_ROUNDS+1];
  logic [KEY_W-1:0] rd_data_q;
  logic             store_we_c;

  // Capture each round key as it is presented, kept for the decrypt direction
  assign store_we_c = (state_d == EMIT) && (state_q != EMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= int'(NUM_ROUNDS); i++) regfile_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (store_we_c) regfile_q[round_cnt_d] <= rk_data_d;
      rd_data_q <= (rd_idx_i <= LAST_RND) ? regfile_q[rd_idx_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule
